// File: rtl/data_memory_responder_if.sv
// Load/store port between the CPU memory stage and the data-memory responder.
//   requestM       : load/store request (master -> slave)
//   writeEnableM   : 1 = store, 0 = load, valid with requestM
//   addressM       : word address
//   writeDataM     : store data
//   readDataM      : registered load result (slave -> master)
//   responseValidM : one-cycle pulse when an access completes
//   errorM         : out-of-range flag, valid with responseValidM
//   stallM         : pipeline hold towards the hazard unit
interface data_memory_responder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             requestM;
  logic             writeEnableM;
  logic [WIDTH-1:0] addressM;
  logic [WIDTH-1:0] writeDataM;
  logic [WIDTH-1:0] readDataM;
  logic             responseValidM;
  logic             errorM;
  logic             stallM;

  modport master (
    output requestM,
    output writeEnableM,
    output addressM,
    output writeDataM,
    input  readDataM,
    input  responseValidM,
    input  errorM,
    input  stallM
  );

  modport slave (
    input  requestM,
    input  writeEnableM,
    input  addressM,
    input  writeDataM,
    output readDataM,
    output responseValidM,
    output errorM,
    output stallM
  );
endinterface

// File: rtl/data_memory_responder.sv
// Multi-cycle data-memory responder for the memory-stage load/store port.
// Accepts one load or store per request, stalls the pipeline for WAITSTATES
// extra cycles, performs the access on an internal word array and reports
// completion with a one-cycle responseValidM pulse.
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : slave side of data_memory_responder_if (WIDTH must match)
module data_memory_responder #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned MEMADDRWIDTH = 8,
  parameter int unsigned WAITSTATES   = 2
) (
  input logic                    clock,
  input logic                    reset,
  data_memory_responder_if.slave bus
);

  localparam int unsigned Depth   = 2 ** MEMADDRWIDTH;
  localparam int unsigned CntW    = (WAITSTATES > 0) ? $clog2(WAITSTATES + 1) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(WAITSTATES);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  addr_q;
  logic [WIDTH-1:0]  wdata_q;
  logic              we_q;
  logic [WIDTH-1:0]  rdata_q;
  logic              valid_q;
  logic              err_q;

  // Contents deliberately not reset.
  logic [WIDTH-1:0]  mem_q [Depth];

  logic [MEMADDRWIDTH-1:0] idx;
  logic                    in_range;
  logic                    access;
  logic                    mem_we;
  logic                    stall;

  assign idx      = addr_q[MEMADDRWIDTH-1:0];
  // Any latched address bit at or above MEMADDRWIDTH makes the access illegal.
  assign in_range = (addr_q >> MEMADDRWIDTH) == '0;
  // Last BUSY cycle: the access happens on this edge.
  assign access   = (state_q == StBusy) && (cnt_q == '0);
  assign mem_we   = access && we_q && in_range && !reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          valid_q <= 1'b0;
          err_q   <= 1'b0;
          if (bus.requestM) begin
            addr_q  <= bus.addressM;
            wdata_q <= bus.writeDataM;
            we_q    <= bus.writeEnableM;
            cnt_q   <= CntInit;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else begin
            state_q <= StDone;
            valid_q <= 1'b1;
            err_q   <= !in_range;
            // Stores leave readDataM untouched; illegal loads return zero.
            if (!we_q) begin
              rdata_q <= in_range ? mem_q[idx] : '0;
            end
          end
        end
        StDone: begin
          // requestM here belongs to the instruction now advancing; ignore it.
          state_q <= StIdle;
          valid_q <= 1'b0;
          err_q   <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[idx] <= wdata_q;
    end
  end

  // IDLE passes requestM straight through so the pipeline holds in the
  // request cycle itself.
  always_comb begin
    stall = 1'b0;
    case (state_q)
      StIdle:  stall = bus.requestM;
      StBusy:  stall = 1'b1;
      default: stall = 1'b0;
    endcase
    if (reset) begin
      stall = 1'b0;
    end
  end

  assign bus.stallM         = stall;
  assign bus.readDataM      = rdata_q;
  assign bus.responseValidM = valid_q;
  assign bus.errorM         = err_q;

endmodule
